// File: rtl/mn_soc_host_de10_nano_soc_timer_irq_servicer.sv
// rtl/mn_soc_host_de10_nano_soc_timer_irq_servicer.sv - Avalon-MM host that services interval timer interrupts
// Arms the timer, acknowledges each timeout and publishes a tick pulse plus counters.
module mn_soc_host_de10_nano_soc_timer_irq_servicer #(
    parameter int          TICK_W       = 32,
    parameter int          SPUR_W       = 16,
    parameter logic [2:0]  STATUS_ADDR  = 3'd0,
    parameter logic [2:0]  CONTROL_ADDR = 3'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear_counts,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [SPUR_W-1:0] spurious_count
);

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_CFG  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;
    localparam logic [2:0] S_HOLD = 3'd6;
    localparam logic [2:0] S_DIS  = 3'd7;

    localparam logic [15:0] CTRL_ITO = 16'h0001;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       timeout_seen;
    logic       unused_readdata;

    assign timeout_seen    = readdata[0];
    assign unused_readdata = ^readdata[15:1];

    // Disable has priority in WAIT so a pending service always finishes first.
    always_comb begin
        next_state = state;
        case (state)
            S_OFF:   if (enable) next_state = S_CFG;
            S_CFG:   next_state = S_WAIT;
            S_WAIT: begin
                if (!enable)  next_state = S_DIS;
                else if (irq) next_state = S_RD;
            end
            S_RD:    next_state = S_CAP;
            S_CAP:   next_state = timeout_seen ? S_CLR : S_WAIT;
            S_CLR:   next_state = S_HOLD;
            S_HOLD:  next_state = S_WAIT;
            S_DIS:   next_state = S_OFF;
            default: next_state = S_OFF;
        endcase
    end

    // Bus outputs are decoded from the state being entered so they register with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_OFF;
            address    <= STATUS_ADDR;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 16'h0000;
            tick       <= 1'b0;
        end else begin
            state      <= next_state;
            address    <= STATUS_ADDR;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 16'h0000;
            tick       <= 1'b0;
            case (next_state)
                S_CFG: begin
                    address    <= CONTROL_ADDR;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    writedata  <= CTRL_ITO;
                end
                S_RD: begin
                    chipselect <= 1'b1;
                end
                S_CLR: begin
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    tick       <= 1'b1;
                end
                S_DIS: begin
                    address    <= CONTROL_ADDR;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_count <= '0;
        end else if (clear_counts) begin
            tick_count <= '0;
        end else if (state == S_CLR) begin
            tick_count <= tick_count + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spurious_count <= '0;
        end else if (clear_counts) begin
            spurious_count <= '0;
        end else if (state == S_CAP && !timeout_seen && spurious_count != '1) begin
            spurious_count <= spurious_count + {{(SPUR_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mn_soc_host_de10_nano_soc_timer_irq_servicer.sv
// tb/tb_mn_soc_host_de10_nano_soc_timer_irq_servicer.sv - scoreboard bench with a behavioural interval timer
module tb_mn_soc_host_de10_nano_soc_timer_irq_servicer;

    localparam int TICK_W = 3;
    localparam int SPUR_W = 2;
    localparam int PER    = 40;

    localparam logic [20:0] EV_RD  = {3'd0, 1'b1, 16'h0000, 1'b0};
    localparam logic [20:0] EV_CLR = {3'd0, 1'b0, 16'h0000, 1'b1};
    localparam logic [20:0] EV_CFG = {3'd1, 1'b0, 16'h0001, 1'b0};
    localparam logic [20:0] EV_DIS = {3'd1, 1'b0, 16'h0000, 1'b0};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              clear_counts = 1'b0;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              irq;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic [SPUR_W-1:0] spurious_count;

    // timer model state
    logic        to_flag;
    logic        ito;
    logic        set_to = 1'b0;
    logic        irq_force = 1'b0;
    logic        per_en = 1'b0;
    int          pcnt;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_ev_cyc = -1;
    int          last_tick_cyc = -1;
    int          idle_err = 0;
    int          spacing_err = 0;
    int          per_ticks = 0;
    int          prev_tick_cyc = -1;
    logic        per_mode = 1'b0;
    logic [20:0] exp_q[$];
    logic [TICK_W-1:0] exp_tick = '0;

    mn_soc_host_de10_nano_soc_timer_irq_servicer #(
        .TICK_W(TICK_W),
        .SPUR_W(SPUR_W),
        .STATUS_ADDR(3'd0),
        .CONTROL_ADDR(3'd1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .clear_counts(clear_counts),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .tick(tick),
        .tick_count(tick_count),
        .spurious_count(spurious_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign irq = (to_flag & ito) | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_flag  <= 1'b0;
            ito      <= 1'b0;
            readdata <= 16'h0000;
            pcnt     <= 0;
        end else begin
            readdata <= (chipselect && write_n) ?
                        ((address == 3'd0) ? {15'h0, to_flag} : {15'h0, ito}) : 16'h0000;
            if (chipselect && !write_n && address == 3'd1) ito <= writedata[0];
            if (set_to || (per_en && pcnt == PER - 1)) to_flag <= 1'b1;
            else if (chipselect && !write_n && address == 3'd0) to_flag <= 1'b0;
            pcnt <= per_en ? ((pcnt == PER - 1) ? 0 : pcnt + 1) : 0;
        end
    end

    // Monitor: every selected bus cycle or tick must match the next expected event.
    always @(negedge clk) begin
        logic [20:0] got;
        logic [20:0] want;
        if (reset_n) begin
            got = {address, write_n, writedata, tick};
            if (chipselect || tick) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_event cycle %0d: unexpected addr=%0d write_n=%0b data=%h tick=%0b, required none",
                             cyc, address, write_n, writedata, tick);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL bus_event cycle %0d: got %h, required %h", cyc, got, want);
                    end
                end
                last_ev_cyc = cyc;
                if (tick) begin
                    last_tick_cyc = cyc;
                    if (per_mode) begin
                        if (prev_tick_cyc >= 0 && cyc - prev_tick_cyc != PER) spacing_err++;
                        prev_tick_cyc = cyc;
                        per_ticks++;
                    end
                end
            end else if (address != 3'd0 || write_n != 1'b1 || writedata != 16'h0) begin
                idle_err++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Raises TO at the end of the current cycle; returns in the first cycle irq is high.
    task automatic fire();
        set_to = 1'b1;
        step();
        set_to = 1'b0;
    endtask

    task automatic service();
        exp_q.push_back(EV_RD);
        exp_q.push_back(EV_CLR);
        fire();
        repeat (5) step();
        exp_tick = exp_tick + 1'b1;
    endtask

    initial begin
        int n;
        int m;
        int k;

        repeat (3) step();
        check("rst_tick_count", tick_count, 0);
        check("rst_spurious_count", spurious_count, 0);
        check("rst_chipselect", chipselect, 0);
        check("rst_write_n", write_n, 1);
        check("rst_address", address, 0);
        check("rst_tick", tick, 0);
        reset_n = 1'b1;
        repeat (2) step();

        exp_q.push_back(EV_CFG);
        m = cyc;
        enable = 1'b1;
        repeat (4) step();
        check("cfg_cycle", last_ev_cyc, m + 1);
        check("cfg_queue", exp_q.size(), 0);
        check("cfg_counts", {tick_count, spurious_count}, 0);

        exp_q.push_back(EV_RD);
        exp_q.push_back(EV_CLR);
        fire();
        n = cyc;
        repeat (4) step();
        check("irq_low_n4", irq, 0);
        step();
        check("irq_low_n5", irq, 0);
        check("tick_cycle", last_tick_cyc, n + 3);
        exp_tick = exp_tick + 1'b1;
        check("tick_count_1", tick_count, exp_tick);
        check("tick_low_after", tick, 0);

        repeat (2) begin
            repeat (3) exp_q.push_back(EV_RD);
            irq_force = 1'b1;
            repeat (9) step();
            irq_force = 1'b0;
            repeat (2) step();
            check("spurious_sat", spurious_count, 3);
        end
        check("spurious_no_tick", tick_count, exp_tick);

        per_mode = 1'b1;
        prev_tick_cyc = -1;
        per_ticks = 0;
        repeat (5) begin
            exp_q.push_back(EV_RD);
            exp_q.push_back(EV_CLR);
        end
        per_en = 1'b1;
        k = 0;
        while (per_ticks < 5 && k < 6 * PER + 50) begin
            step();
            k++;
        end
        per_en = 1'b0;
        check("periodic_ticks", per_ticks, 5);
        repeat (6) step();
        per_mode = 1'b0;
        exp_tick = exp_tick + 3'd5;
        check("periodic_spacing_err", spacing_err, 0);
        check("periodic_tick_count", tick_count, exp_tick);
        check("periodic_spurious", spurious_count, 3);

        exp_q.push_back(EV_RD);
        exp_q.push_back(EV_CLR);
        exp_q.push_back(EV_DIS);
        fire();
        n = cyc;
        step();
        step();
        enable = 1'b0;
        repeat (6) step();
        exp_tick = exp_tick + 1'b1;
        check("dis_cycle", last_ev_cyc, n + 6);
        check("dis_tick_count", tick_count, exp_tick);
        drain("dis_queue", 5);
        check("dis_ito_cleared", ito, 0);

        exp_q.push_back(EV_CFG);
        enable = 1'b1;
        drain("reenable_queue", 5);
        step();

        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        exp_tick = '0;
        check("clear_tick", tick_count, 0);
        check("clear_spur", spurious_count, 0);

        repeat (7) service();
        check("preload_all_ones", tick_count, 7);

        exp_q.push_back(EV_RD);
        exp_q.push_back(EV_CLR);
        fire();
        repeat (3) step();
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        check("clear_wins", tick_count, 0);
        repeat (2) step();
        exp_tick = '0;

        repeat (7) service();
        check("reload_all_ones", tick_count, 7);
        service();
        check("wrap_to_zero", tick_count, exp_tick);

        drain("final_queue", 10);
        check("idle_bus_errors", idle_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mn_soc_host_de10_nano_soc_timer_irq_servicer.md
# mn_soc_host_de10_nano_soc_timer_irq_servicer

Hardware interrupt servicer for the system interval timer, acting as its Avalon-MM host. On enable it arms the timer's interrupt. On each timer `irq` it reads the status register, acknowledges the timeout by writing status, and then emits a one-cycle `tick` plus running counters. This offloads the 1 ms (49 999 + 1 cycle) tick from the CPU.

## Interface
- `TICK_W`, 32, width of `tick_count`
- `SPUR_W`, 16, width of `spurious_count`
- `STATUS_ADDR`, 3'd0, timer status register word address
- `CONTROL_ADDR`, 3'd1, timer control register word address

Ports:
- `clk`  in  1  single system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  level; 1 = arm and service timer, 0 = disarm
- `clear_counts`  in  1  synchronous clear of both counters
- `address`  out  3  to timer `address`
- `chipselect`  out  1  to timer `chipselect`
- `write_n`  out  1  to timer `write_n` (0 = write, 1 = read when selected)
- `writedata`  out  16  to timer `writedata`
- `readdata`  in  16  from timer; registered, valid one cycle after the address is presented
- `irq`  in  1  timer interrupt, level, held until status is written
- `tick`  out  1  one-cycle pulse per acknowledged timeout
- `tick_count`  out  TICK_W  acknowledged timeouts, wraps
- `spurious_count`  out  SPUR_W  services that read TO=0, saturating

## Operation
- Moore FSM. All outputs are registered and change on the edge that enters the state.
- Reset values: state OFF, `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `tick`=0, both counts 0.
- Idle bus (all states except CFG, RD, CLR, DIS): `chipselect`=0, `write_n`=1, `writedata`=0, `address`=STATUS_ADDR.
- States:
  - OFF: idle. `enable`=1 → CFG.
  - CFG: write CONTROL_ADDR, data 16'h0001 (ITO=1), one cycle → WAIT.
  - WAIT: `enable`=0 → DIS; else `irq`=1 → RD. `enable`=0 has priority over `irq`.
  - RD: `chipselect`=1, `write_n`=1, `address`=STATUS_ADDR, one cycle → CAP.
  - CAP: bus idle; sample `readdata[0]` (TO). TO=1 → CLR. TO=0 → increment `spurious_count` (saturate at all-ones), → WAIT.
  - CLR: write STATUS_ADDR, data 16'h0000; `tick`=1; `tick_count` increments at the end of this cycle (wraps from all-ones to 0) → HOLD.
  - HOLD: idle guard cycle → WAIT.
  - DIS: write CONTROL_ADDR, data 16'h0000, one cycle → OFF.
- Boundary cases:
  - `enable` falling during RD/CAP/CLR/HOLD: the sequence completes; WAIT then goes to DIS. A pending timeout is never left unacknowledged.
  - `enable` rising during DIS: DIS completes, OFF is entered, then CFG follows.
  - `clear_counts` coincident with an increment: clear wins and the counter reads 0 next cycle.
  - Spurious `irq` persisting high: each RD/CAP loop counts once, 3 cycles per loop. There is no lockup of the bus.
  - Reset mid-operation: immediate return to reset values. The timer is reset by the same `reset_n`, so no handshake is owed.

## Timing
- `irq` first high in WAIT cycle N → RD at N+1, CAP at N+2, CLR (tick=1) at N+3, HOLD at N+4, WAIT at N+5.
- The timer drops `irq` in cycle N+4, because its TO flag is cleared by the N+3 write edge. At N+5 WAIT therefore sees `irq`=0.
- Service occupies 5 cycles, far below the 50 000-cycle timer period. A back-to-back timeout cannot be missed.
- `enable` rising in cycle M (state OFF) → CFG write at M+1 → WAIT at M+2.
- Every bus write is exactly one cycle with `chipselect`=1; the timer has no waitrequest.
- The read is one cycle with fixed latency 1.

## Test plan
- Reset, then `enable`=1: a single write to address 1 with data 0x0001 one cycle later; no other bus activity; counts = 0.
- Timer model asserts `irq` with TO=1: RD(addr 0) → CAP → CLR write (addr 0, data 0) at N+3; `tick` high exactly one cycle; `tick_count`=1; `irq` low by N+5.
- Run 100 timer periods against the real timer RTL: `tick_count`=100, `spurious_count`=0, tick spacing exactly 50 000 cycles.
- Force `irq`=1 for 9 cycles with status TO=0: `spurious_count`=3, no `tick`, no status write. Preload `spurious_count` to all-ones and it stays at all-ones.
- Drop `enable` during CAP: CLR and HOLD complete, then WAIT, then DIS writes addr 1 data 0x0000, then OFF. `tick_count` is incremented once.
- Preload `tick_count` to all-ones and assert `clear_counts` together with CLR: the count is 0 (clear wins). Without `clear_counts`, the all-ones value wraps to 0.
